// File: rtl/ysyx_23060077_riscv_wb_arb.sv
// ysyx_23060077_riscv_wb_arb: round-robin write-back arbiter with register busy scoreboard
module ysyx_23060077_riscv_wb_arb #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic                  iss_wb,
    input  logic [REG_WIDTH-1:0]  iss_rd_addr,
    input  logic                  iss_rs1_use,
    input  logic [REG_WIDTH-1:0]  iss_rs1_addr,
    input  logic                  iss_rs2_use,
    input  logic [REG_WIDTH-1:0]  iss_rs2_addr,
    output logic                  iss_stall,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [REG_WIDTH-1:0]  exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_WIDTH-1:0]  lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rd_en,
    output logic [REG_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic                  last_grant;
    logic [REG_COUNT-1:0]  busy, busy_nxt;
    logic                  grant_exu, grant_lsu, grant, fire;
    logic [REG_WIDTH-1:0]  g_addr;
    logic [DATA_WIDTH-1:0] g_data;

    // last_grant: 0 = EXU, 1 = LSU; on a tie the other side wins
    assign grant_exu = exu_valid & (~lsu_valid | last_grant);
    assign grant_lsu = lsu_valid & (~exu_valid | ~last_grant);
    assign grant     = grant_exu | grant_lsu;
    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;
    assign g_addr    = grant_exu ? exu_addr : lsu_addr;
    assign g_data    = grant_exu ? exu_data : lsu_data;

    assign iss_stall = iss_valid & ((iss_rs1_use & busy[iss_rs1_addr]) |
                                    (iss_rs2_use & busy[iss_rs2_addr]) |
                                    (iss_wb & busy[iss_rd_addr]));
    assign fire = iss_valid & ~iss_stall;

    // clear applied before set so a same-edge issue to the same register keeps it busy
    always_comb begin
        busy_nxt = busy;
        if (rd_en) busy_nxt[rd_addr] = 1'b0;
        if (fire && iss_wb && iss_rd_addr != '0) busy_nxt[iss_rd_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            busy       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
        end else begin
            busy  <= busy_nxt;
            rd_en <= grant && g_addr != '0;
            if (grant) begin
                last_grant <= grant_lsu;
                rd_addr    <= g_addr;
                rd_data    <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060077_riscv_wb_arb.sv
// tb_ysyx_23060077_riscv_wb_arb: directed checks of arbitration, commit timing and scoreboard hazards
module tb_ysyx_23060077_riscv_wb_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_wb, iss_rs1_use, iss_rs2_use;
    logic [4:0]  iss_rd_addr, iss_rs1_addr, iss_rs2_addr;
    logic        iss_stall;
    logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]  exu_addr, lsu_addr;
    logic [31:0] exu_data, lsu_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    ysyx_23060077_riscv_wb_arb dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_rd_addr(iss_rd_addr),
        .iss_rs1_use(iss_rs1_use), .iss_rs1_addr(iss_rs1_addr),
        .iss_rs2_use(iss_rs2_use), .iss_rs2_addr(iss_rs2_addr),
        .iss_stall(iss_stall),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_addr(exu_addr), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle;
        iss_valid = 0; iss_wb = 0; iss_rs1_use = 0; iss_rs2_use = 0;
        iss_rd_addr = 0; iss_rs1_addr = 0; iss_rs2_addr = 0;
        exu_valid = 0; exu_addr = 0; exu_data = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    endtask

    task do_reset;
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task test_reset;
        do_reset();
        total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", rd_en); else passed++;
        total++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); else passed++;
        total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else passed++;
        total++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) $display("FAIL reset_ready got %b%b exp 00", exu_ready, lsu_ready); else passed++;
        iss_valid = 1; iss_rs1_use = 1;
        for (int i = 0; i < 32; i++) begin
            iss_rs1_addr = 5'(i);
            #1;
            total++; if (iss_stall !== 1'b0) $display("FAIL reset_busy_%0d got stall %b exp 0", i, iss_stall); else passed++;
        end
        idle();
    endtask

    task test_exu_only;
        exu_valid = 1; exu_addr = 5; exu_data = 32'h1234;
        #3;
        total++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) $display("FAIL exu_only_ready got %b%b exp 10", exu_ready, lsu_ready); else passed++;
        tick();
        exu_valid = 0;
        total++; if (rd_en !== 1'b1) $display("FAIL exu_only_en got %b exp 1", rd_en); else passed++;
        total++; if (rd_addr !== 5'd5) $display("FAIL exu_only_addr got %0d exp 5", rd_addr); else passed++;
        total++; if (rd_data !== 32'h1234) $display("FAIL exu_only_data got %h exp 1234", rd_data); else passed++;
        tick();
        total++; if (rd_en !== 1'b0) $display("FAIL exu_only_idle_en got %b exp 0", rd_en); else passed++;
        total++; if (rd_addr !== 5'd5) $display("FAIL exu_only_hold_addr got %0d exp 5", rd_addr); else passed++;
    endtask

    task test_round_robin;
        do_reset();
        exu_valid = 1; exu_addr = 1; exu_data = 32'hA;
        lsu_valid = 1; lsu_addr = 2; lsu_data = 32'hB;
        for (int k = 0; k < 4; k++) begin
            #3;
            total++;
            if (exu_ready !== (k % 2 == 0) || lsu_ready !== (k % 2 == 1))
                $display("FAIL rr_grant_%0d got %b%b exp %b%b", k, exu_ready, lsu_ready, k % 2 == 0, k % 2 == 1);
            else passed++;
            tick();
            total++;
            if (rd_en !== 1'b1 || rd_addr !== ((k % 2 == 0) ? 5'd1 : 5'd2) || rd_data !== ((k % 2 == 0) ? 32'hA : 32'hB))
                $display("FAIL rr_commit_%0d got en=%b addr=%0d data=%h", k, rd_en, rd_addr, rd_data);
            else passed++;
        end
        idle();
        tick();
        total++; if (rd_en !== 1'b0) $display("FAIL rr_drain got %b exp 0", rd_en); else passed++;
    endtask

    task test_raw;
        iss_valid = 1; iss_wb = 1; iss_rd_addr = 7;
        #3;
        total++; if (iss_stall !== 1'b0) $display("FAIL raw_issue got %b exp 0", iss_stall); else passed++;
        tick();
        iss_wb = 0; iss_rs1_use = 1; iss_rs1_addr = 7;
        lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
        #3;
        total++; if (iss_stall !== 1'b1) $display("FAIL raw_stall got %b exp 1", iss_stall); else passed++;
        total++; if (lsu_ready !== 1'b1) $display("FAIL raw_lsu_ready got %b exp 1", lsu_ready); else passed++;
        tick();
        lsu_valid = 0;
        total++; if (rd_en !== 1'b1 || rd_addr !== 5'd7) $display("FAIL raw_commit got en=%b addr=%0d exp en=1 addr=7", rd_en, rd_addr); else passed++;
        total++; if (iss_stall !== 1'b1) $display("FAIL raw_stall_commit got %b exp 1", iss_stall); else passed++;
        tick();
        total++; if (iss_stall !== 1'b0) $display("FAIL raw_release got %b exp 0", iss_stall); else passed++;
        idle();
    endtask

    task test_waw;
        exu_valid = 1; exu_addr = 3; exu_data = 32'h33;
        #3;
        total++; if (exu_ready !== 1'b1) $display("FAIL waw_exu_ready got %b exp 1", exu_ready); else passed++;
        tick();
        exu_valid = 0;
        iss_valid = 1; iss_wb = 1; iss_rd_addr = 3;
        #3;
        total++; if (rd_en !== 1'b1 || rd_addr !== 5'd3) $display("FAIL waw_commit got en=%b addr=%0d exp en=1 addr=3", rd_en, rd_addr); else passed++;
        total++; if (iss_stall !== 1'b0) $display("FAIL waw_issue got %b exp 0", iss_stall); else passed++;
        tick();
        #3;
        total++; if (iss_stall !== 1'b1) $display("FAIL waw_set_wins got %b exp 1", iss_stall); else passed++;
        iss_wb = 0; iss_rs2_use = 1; iss_rs2_addr = 3;
        #1;
        total++; if (iss_stall !== 1'b1) $display("FAIL waw_rs2 got %b exp 1", iss_stall); else passed++;
        idle();
        exu_valid = 1; exu_addr = 3; exu_data = 32'h34;
        tick();
        exu_valid = 0;
        tick();
        iss_valid = 1; iss_wb = 1; iss_rd_addr = 3;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL waw_cleared got %b exp 0", iss_stall); else passed++;
        idle();
    endtask

    task test_x0;
        iss_valid = 1; iss_wb = 1; iss_rd_addr = 0;
        #3;
        total++; if (iss_stall !== 1'b0) $display("FAIL x0_issue got %b exp 0", iss_stall); else passed++;
        tick();
        iss_wb = 0; iss_rs1_use = 1; iss_rs1_addr = 0;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL x0_read got %b exp 0", iss_stall); else passed++;
        idle();
        exu_valid = 1; exu_addr = 0; exu_data = 32'hFF;
        #1;
        total++; if (exu_ready !== 1'b1) $display("FAIL x0_ready got %b exp 1", exu_ready); else passed++;
        tick();
        exu_valid = 0;
        total++; if (rd_en !== 1'b0) $display("FAIL x0_rd_en got %b exp 0", rd_en); else passed++;
        tick();
    endtask

    task test_reset_mid_op;
        iss_valid = 1; iss_wb = 1; iss_rd_addr = 9;
        tick();
        idle();
        exu_valid = 1; exu_addr = 9; exu_data = 32'h99;
        rst_n = 0;
        tick();
        rst_n = 1;
        exu_valid = 0;
        total++; if (rd_en !== 1'b0) $display("FAIL rst_mid_rd_en got %b exp 0", rd_en); else passed++;
        iss_valid = 1; iss_rs1_use = 1; iss_rs1_addr = 9;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", iss_stall); else passed++;
        idle();
    endtask

    initial begin
        test_reset();
        test_exu_only();
        test_round_robin();
        test_raw();
        test_waw();
        test_x0();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
